// File: rtl/cordic_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_job_scheduler
//  Description : Shares one free-running, fixed-latency pipelined CORDIC
//                datapath between two requesters. Jobs are arbitrated
//                round-robin and tagged with the requester id in a shadow tag
//                pipeline. Returning results are steered into per-requester
//                response FIFOs. Credits cover both in-flight jobs and queued
//                results, so a result always has a FIFO slot when it returns.
//                A halt/drain state machine stops issuing and reports when
//                the datapath is empty.
//  Ports       : clk, rst (async, active high)
//                req{0,1}_valid/ready/x/y/mode : job request handshakes
//                dp_valid/x/y/mode (registered) : job to datapath
//                dp_res_a/b                     : datapath results, LAT later
//                rsp{0,1}_valid/ready/a/b       : response handshakes
//                halt / halted                  : stop-and-drain control
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_job_scheduler #(
    parameter int DW         = 16,
    parameter int LAT        = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_x,
    input  logic [DW-1:0] req0_y,
    input  logic          req0_mode,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_x,
    input  logic [DW-1:0] req1_y,
    input  logic          req1_mode,
    output logic          dp_valid,
    output logic [DW-1:0] dp_x,
    output logic [DW-1:0] dp_y,
    output logic          dp_mode,
    input  logic [DW-1:0] dp_res_a,
    input  logic [DW-1:0] dp_res_b,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_a,
    output logic [DW-1:0] rsp0_b,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_a,
    output logic [DW-1:0] rsp1_b,
    input  logic          halt,
    output logic          halted
);

    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_SW = c_CW + 1;
    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_SW-1:0] c_DEPTH   = c_SW'(FIFO_DEPTH);
    localparam logic [c_PW-1:0] c_PTR_MAX = c_PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_halted;
    logic            r_last_grant;
    logic            r_dp_valid;
    logic [DW-1:0]   r_dp_x;
    logic [DW-1:0]   r_dp_y;
    logic            r_dp_mode;
    logic            r_dp_id;
    logic [LAT-1:0]  r_tag_v;
    logic [LAT-1:0]  r_tag_id;

    logic [LAT:0]    w_tag_v_sh;
    logic [LAT:0]    w_tag_id_sh;
    logic            w_exit_v;
    logic            w_exit_id;
    logic            w_run;
    logic [1:0]      w_req_valid;
    logic [1:0]      w_rsp_ready;
    logic [1:0]      w_credit_ok;
    logic [1:0]      w_idle_nxt;
    logic [1:0]      w_elig;
    logic [1:0]      w_grant;
    logic [1:0]      w_rsp_valid;
    logic [DW-1:0]   w_rsp_a [2];
    logic [DW-1:0]   w_rsp_b [2];

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    // ------------------------------------------------------------------
    // Arbitration. A requester is only eligible while the FSM is in RUN
    // and halt is low, so the cycle that samples halt high grants nothing.
    // ------------------------------------------------------------------
    assign w_run  = (r_state == S_RUN) && !halt;
    assign w_elig = w_req_valid & w_credit_ok & {2{w_run}};

    always_comb begin
        w_grant = 2'b00;
        if (&w_elig) begin
            // Both eligible: favour the one that was not granted last.
            w_grant = r_last_grant ? 2'b01 : 2'b10;
        end else begin
            w_grant = w_elig;
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // ------------------------------------------------------------------
    // Issue register towards the datapath. Operands hold when idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_valid   <= 1'b0;
            r_dp_x       <= '0;
            r_dp_y       <= '0;
            r_dp_mode    <= 1'b0;
            r_dp_id      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_dp_valid <= |w_grant;
            if (|w_grant) begin
                r_dp_x       <= w_grant[1] ? req1_x    : req0_x;
                r_dp_y       <= w_grant[1] ? req1_y    : req0_y;
                r_dp_mode    <= w_grant[1] ? req1_mode : req0_mode;
                r_dp_id      <= w_grant[1];
                r_last_grant <= w_grant[1];
            end
        end
    end

    assign dp_valid = r_dp_valid;
    assign dp_x     = r_dp_x;
    assign dp_y     = r_dp_y;
    assign dp_mode  = r_dp_mode;

    // ------------------------------------------------------------------
    // Shadow tag pipeline: the last stage lines up with dp_res_* for the
    // job that was on dp_* LAT cycles earlier. Clearing it on reset is what
    // makes stale datapath results harmless.
    // ------------------------------------------------------------------
    assign w_tag_v_sh  = {r_tag_v,  r_dp_valid};
    assign w_tag_id_sh = {r_tag_id, r_dp_id};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            r_tag_v  <= w_tag_v_sh[LAT-1:0];
            r_tag_id <= w_tag_id_sh[LAT-1:0];
        end
    end

    assign w_exit_v  = r_tag_v[LAT-1];
    assign w_exit_id = r_tag_id[LAT-1];

    // ------------------------------------------------------------------
    // Per-requester credit tracking and response FIFO.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_req
        logic [c_CW-1:0] r_inflight;
        logic [c_CW-1:0] w_inflight_nxt;
        logic [c_CW-1:0] r_count;
        logic [c_PW-1:0] r_wr_ptr;
        logic [c_PW-1:0] r_rd_ptr;
        logic [DW-1:0]   r_mem_a [FIFO_DEPTH];
        logic [DW-1:0]   r_mem_b [FIFO_DEPTH];
        logic            w_issue;
        logic            w_push;
        logic            w_pop;

        assign w_issue = w_grant[i];
        assign w_push  = w_exit_v && (w_exit_id == 1'(i));
        assign w_pop   = (r_count != '0) && w_rsp_ready[i];

        always_comb begin
            w_inflight_nxt = r_inflight;
            if (w_issue && !w_push) begin
                w_inflight_nxt = r_inflight + c_CW'(1);
            end else if (!w_issue && w_push) begin
                w_inflight_nxt = r_inflight - c_CW'(1);
            end
        end

        // Every job holds one credit from issue until its result is popped.
        assign w_credit_ok[i] = ({1'b0, r_inflight} + {1'b0, r_count}) < c_DEPTH;
        assign w_idle_nxt[i]  = (w_inflight_nxt == '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_inflight <= '0;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                r_inflight <= w_inflight_nxt;
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == c_PTR_MAX) ? '0 : r_wr_ptr + c_PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_PTR_MAX) ? '0 : r_rd_ptr + c_PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_CW'(1);
                end
            end
        end

        // Storage needs no reset: r_count gates visibility of every entry.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem_a[r_wr_ptr] <= dp_res_a;
                r_mem_b[r_wr_ptr] <= dp_res_b;
            end
        end

        assign w_rsp_valid[i] = (r_count != '0);
        assign w_rsp_a[i]     = r_mem_a[r_rd_ptr];
        assign w_rsp_b[i]     = r_mem_b[r_rd_ptr];
    end

    assign rsp0_valid = w_rsp_valid[0];
    assign rsp0_a     = w_rsp_a[0];
    assign rsp0_b     = w_rsp_b[0];
    assign rsp1_valid = w_rsp_valid[1];
    assign rsp1_a     = w_rsp_a[1];
    assign rsp1_b     = w_rsp_b[1];

    // ------------------------------------------------------------------
    // Halt/drain FSM. DRAIN looks at the post-update in-flight counts so
    // halted rises in the cycle right after the last tag leaves.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (halt) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!halt) begin
                        r_state <= S_RUN;
                    end else if (&w_idle_nxt) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!halt) begin
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_cordic_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_job_scheduler
//  Description : Self-checking bench for cordic_job_scheduler. A fixed-latency
//                datapath stand-in returns a = x+1, b = y+2. A queue-based
//                reference model predicts grants, datapath issue and the
//                cycle at which each response becomes visible.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_job_scheduler;

    localparam int c_DW  = 16;
    localparam int c_LAT = 9;
    localparam int c_FD  = 4;
    localparam logic [c_DW-1:0] c_ONE = 16'd1;
    localparam logic [c_DW-1:0] c_TWO = 16'd2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0_valid, req0_ready, req0_mode;
    logic [c_DW-1:0] req0_x, req0_y;
    logic            req1_valid, req1_ready, req1_mode;
    logic [c_DW-1:0] req1_x, req1_y;
    logic            dp_valid, dp_mode;
    logic [c_DW-1:0] dp_x, dp_y, dp_res_a, dp_res_b;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [c_DW-1:0] rsp0_a, rsp0_b, rsp1_a, rsp1_b;
    logic            halt, halted;

    cordic_job_scheduler #(.DW(c_DW), .LAT(c_LAT), .FIFO_DEPTH(c_FD)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
        .req0_y(req0_y), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
        .req1_y(req1_y), .req1_mode(req1_mode),
        .dp_valid(dp_valid), .dp_x(dp_x), .dp_y(dp_y), .dp_mode(dp_mode),
        .dp_res_a(dp_res_a), .dp_res_b(dp_res_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_a(rsp0_a), .rsp0_b(rsp0_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_a(rsp1_a), .rsp1_b(rsp1_b),
        .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    // Free-running datapath stand-in; never reset, so stale results emerge.
    logic [c_DW-1:0] pa [c_LAT];
    logic [c_DW-1:0] pb [c_LAT];
    always @(posedge clk) begin
        pa[0] <= dp_x + c_ONE;
        pb[0] <= dp_y + c_TWO;
        for (int i = 1; i < c_LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign dp_res_a = pa[c_LAT-1];
    assign dp_res_b = pb[c_LAT-1];

    // ---------------- reference model state ----------------
    typedef struct {
        logic [c_DW-1:0] a;
        logic [c_DW-1:0] b;
        int              due;
    } rsp_t;

    typedef struct {
        bit v0;
        bit v1;
        bit er0;
        bit er1;
    } vec_t;

    rsp_t            q0[$];
    rsp_t            q1[$];
    int              m_out0, m_out1;
    bit              m_last;
    bit              m_dpv;
    logic [c_DW-1:0] m_dpx, m_dpy;
    bit              m_dpm;
    bit              m_en = 1'b0;
    int              cyc = 0;
    int              tests = 0;
    int              fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_out0 = 0;
        m_out1 = 0;
        m_last = 1'b1;
        m_dpv  = 1'b0;
    endtask

    // One cycle of the model: compare what the DUT shows now, then account
    // for what the coming clock edge does. Assumes halt stays low.
    task automatic model_cycle();
        bit   e0, e1, g0, g1, ev0, ev1;
        rsp_t r;
        e0 = req0_valid && (m_out0 < c_FD);
        e1 = req1_valid && (m_out1 < c_FD);
        g0 = e0 && (!e1 || m_last);
        g1 = e1 && !g0;
        chk("m_req0_ready", req0_ready, g0);
        chk("m_req1_ready", req1_ready, g1);
        chk("m_dp_valid", dp_valid, m_dpv);
        if (m_dpv) begin
            chk("m_dp_x", dp_x, m_dpx);
            chk("m_dp_y", dp_y, m_dpy);
            chk("m_dp_mode", dp_mode, m_dpm);
        end
        ev0 = (q0.size() > 0) && (q0[0].due <= cyc);
        ev1 = (q1.size() > 0) && (q1[0].due <= cyc);
        chk("m_rsp0_valid", rsp0_valid, ev0);
        chk("m_rsp1_valid", rsp1_valid, ev1);
        if (ev0) begin
            chk("m_rsp0_a", rsp0_a, q0[0].a);
            chk("m_rsp0_b", rsp0_b, q0[0].b);
            if (rsp0_ready) begin
                void'(q0.pop_front());
                m_out0--;
            end
        end
        if (ev1) begin
            chk("m_rsp1_a", rsp1_a, q1[0].a);
            chk("m_rsp1_b", rsp1_b, q1[0].b);
            if (rsp1_ready) begin
                void'(q1.pop_front());
                m_out1--;
            end
        end
        m_dpv = g0 || g1;
        if (g0) begin
            r.a = req0_x + c_ONE; r.b = req0_y + c_TWO; r.due = cyc + c_LAT + 2;
            q0.push_back(r);
            m_out0++;
            m_last = 1'b0;
            m_dpx = req0_x; m_dpy = req0_y; m_dpm = req0_mode;
        end else if (g1) begin
            r.a = req1_x + c_ONE; r.b = req1_y + c_TWO; r.due = cyc + c_LAT + 2;
            q1.push_back(r);
            m_out1++;
            m_last = 1'b1;
            m_dpx = req1_x; m_dpy = req1_y; m_dpm = req1_mode;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (m_en) model_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_x = '0; req0_y = '0; req0_mode = 0;
        req1_valid = 0; req1_x = '0; req1_y = '0; req1_mode = 0;
        rsp0_ready = 1; rsp1_ready = 1; halt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += 2;
        model_reset();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t            tbl [8];
        int              n, acc0, pops;
        bit              regrant;
        logic [c_DW-1:0] rec [4];

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dp_valid_during", dp_valid, 0);
        do_reset();
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_dp_x", dp_x, 0);
        chk("rst_dp_y", dp_y, 0);
        chk("rst_dp_mode", dp_mode, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_halted", halted, 0);
        m_en = 1'b1;

        // ---------------- table: round-robin grants ----------------
        for (int i = 0; i < 8; i++) begin
            req0_valid = tbl[i].v0; req0_x = 16'($urandom); req0_y = 16'($urandom);
            req1_valid = tbl[i].v1; req1_x = 16'($urandom); req1_y = 16'($urandom);
            #1;
            chk("tbl_req0_ready", req0_ready, tbl[i].er0);
            chk("tbl_req1_ready", req1_ready, tbl[i].er1);
            step();
        end
        idle_inputs();
        repeat (20) step();

        // ---------------- single job latency ----------------
        do_reset();
        req0_valid = 1; req0_x = 16'd1000; req0_y = 16'd0; req0_mode = 1;
        #1;
        chk("single_ready", req0_ready, 1);
        step();
        idle_inputs();
        #1;
        chk("single_dp_valid", dp_valid, 1);
        chk("single_dp_x", dp_x, 1000);
        chk("single_dp_mode", dp_mode, 1);
        n = 1;
        while (!rsp0_valid && n < 30) begin
            chk("single_rsp1_quiet", rsp1_valid, 0);
            step();
            n++;
        end
        chk("single_latency", n, c_LAT + 2);
        chk("single_a", rsp0_a, 1001);
        chk("single_b", rsp0_b, 2);
        step();
        repeat (3) step();

        // ---------------- backpressure on requester 0 ----------------
        acc0 = 0;
        rsp0_ready = 0;
        for (int i = 0; i < 40; i++) begin
            req0_valid = 1; req0_x = 16'($urandom); req0_y = 16'($urandom); req0_mode = 1'($urandom);
            req1_valid = 1; req1_x = 16'($urandom); req1_y = 16'($urandom); req1_mode = 1'($urandom);
            #1;
            if (req0_ready) begin
                if (acc0 < 4) rec[acc0] = req0_x;
                acc0++;
            end
            step();
        end
        chk("bp_req0_accepts", acc0, 4);
        rsp0_ready = 1;
        pops = 0;
        regrant = 0;
        for (int i = 0; i < 30; i++) begin
            req0_x = 16'($urandom); req1_x = 16'($urandom);
            #1;
            if (rsp0_valid && pops < 4) begin
                chk("bp_pop_order", rsp0_a, rec[pops] + c_ONE);
                pops++;
            end
            if (req0_ready) regrant = 1;
            step();
        end
        chk("bp_pops", pops, 4);
        chk("bp_regrant", regrant, 1);
        idle_inputs();
        repeat (25) step();

        // ---------------- full FIFO with simultaneous push/pop ----------------
        rsp0_ready = 0;
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1; req0_x = 16'(100 + k); req0_y = 16'(k);
            #1;
            chk("full_issue_ready", req0_ready, 1);
            step();
        end
        req0_valid = 0;
        repeat (c_LAT) step();
        // This is the cycle job 4's tag exits while three results wait.
        #1;
        chk("full_rsp_valid", rsp0_valid, 1);
        chk("full_first_a", rsp0_a, 101);
        rsp0_ready = 1;
        step();
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("full_pop_valid", rsp0_valid, 1);
            chk("full_pop_a", rsp0_a, 16'(101 + k));
            step();
        end
        #1;
        chk("full_empty", rsp0_valid, 0);
        step();

        // ---------------- halt / drain ----------------
        m_en = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1; req1_valid = 1; req0_x = 16'(k); req1_x = 16'(k);
            step();
        end
        halt = 1;
        for (int k = 0; k <= c_LAT + 4; k++) begin
            #1;
            chk("halt_req0_ready", req0_ready, 0);
            chk("halt_req1_ready", req1_ready, 0);
            chk("halt_halted", halted, (k >= c_LAT + 1) ? 1 : 0);
            step();
        end
        halt = 0;
        req1_valid = 0;
        #1;
        chk("resume_halted_hold", halted, 1);
        chk("resume_ready_hold", req0_ready, 0);
        step();
        #1;
        chk("resume_req0_ready", req0_ready, 1);
        chk("resume_halted", halted, 0);
        step();
        idle_inputs();

        // ---------------- reset mid-operation ----------------
        do_reset();
        m_en = 1'b1;
        req0_valid = 1; req0_x = 16'd11; step();
        req0_valid = 0; req1_valid = 1; req1_x = 16'd22; step();
        req1_valid = 0;
        repeat (3) step();
        req0_valid = 1; req0_x = 16'd33; step();
        req0_valid = 0;
        m_en = 1'b0;
        #1;
        chk("midrst_dp_before", dp_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_dp_valid", dp_valid, 0);
        chk("midrst_dp_x", dp_x, 0);
        chk("midrst_rsp0", rsp0_valid, 0);
        chk("midrst_rsp1", rsp1_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_reset();
        m_en = 1'b1;
        for (int k = 0; k < c_LAT + 4; k++) begin
            #1;
            chk("midrst_stale_rsp0", rsp0_valid, 0);
            chk("midrst_stale_rsp1", rsp1_valid, 0);
            step();
        end
        req1_valid = 1; req1_x = 16'd500; req1_y = 16'd7;
        step();
        req1_valid = 0;
        n = 1;
        while (!rsp1_valid && n < 30) begin
            step();
            n++;
        end
        chk("midrst_latency", n, c_LAT + 2);
        chk("midrst_a", rsp1_a, 501);
        chk("midrst_b", rsp1_b, 9);
        step();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            req0_x = 16'($urandom); req0_y = 16'($urandom); req0_mode = 1'($urandom);
            req1_x = 16'($urandom); req1_y = 16'($urandom); req1_mode = 1'($urandom);
            rsp0_ready = ($urandom_range(0, 9) < 6);
            rsp1_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        idle_inputs();
        repeat (30) step();
        #1;
        chk("final_rsp0_empty", rsp0_valid, 0);
        chk("final_rsp1_empty", rsp1_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
